// File: rtl/addition_normalizer_pipe_if.sv
// Handshake and data bundle between the mantissa adder, the normaliser and the rounding stage.
// The slave modport is the normaliser's view; the master modport drives operands and sinks results.
interface addition_normalizer_pipe_if #(
   parameter int unsigned MENT_WIDTH = 23,
   parameter int unsigned EXPO_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [EXPO_WIDTH-1:0] bigger_exponent_in;
   logic [MENT_WIDTH+1:0] sum_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [MENT_WIDTH-1:0] normalized_mentissa_out;
   logic [EXPO_WIDTH-1:0] normalized_exponent_out;
   logic                  round_bit_out;
   logic                  zero_out;
   logic                  underflow_out;
   logic                  overflow_out;

   modport slave (
      input  in_valid, bigger_exponent_in, sum_in, out_ready,
      output in_ready, out_valid, normalized_mentissa_out, normalized_exponent_out,
             round_bit_out, zero_out, underflow_out, overflow_out
   );

   modport master (
      output in_valid, bigger_exponent_in, sum_in, out_ready,
      input  in_ready, out_valid, normalized_mentissa_out, normalized_exponent_out,
             round_bit_out, zero_out, underflow_out, overflow_out
   );
endinterface

// File: rtl/addition_normalizer_pipe.sv
// Two-stage valid/ready normaliser for the FP adder: S1 captures exponent, sum and leading-zero count,
// S2 captures the shifted fraction, final exponent and the zero/underflow/overflow/round flags.
module addition_normalizer_pipe #(
   parameter int unsigned MENT_WIDTH = 23,
   parameter int unsigned EXPO_WIDTH = 8
) (
   input logic                   clk,
   input logic                   rst,
   addition_normalizer_pipe_if.slave bus
);
   localparam int unsigned LZW = $clog2(MENT_WIDTH + 2);
   localparam int unsigned XW  = EXPO_WIDTH + 1;
   localparam logic [XW-1:0] EMAX = {1'b0, {EXPO_WIDTH{1'b1}}};

   logic                  w_s1_adv;
   logic                  w_s2_adv;
   logic [LZW-1:0]        w_lz;

   logic                  r_s1_valid;
   logic [EXPO_WIDTH-1:0] r_s1_exp;
   logic [MENT_WIDTH+1:0] r_s1_sum;
   logic [LZW-1:0]        r_s1_lz;

   logic [XW-1:0]         w_e_ext;
   logic [XW-1:0]         w_e_inc;
   logic [XW-1:0]         w_lz_ext;
   logic [LZW-1:0]        w_shamt;
   logic                  w_norm;
   logic [MENT_WIDTH-1:0] w_frac;
   logic [EXPO_WIDTH-1:0] w_exp;
   logic                  w_rb;
   logic                  w_zero;
   logic                  w_uf;
   logic                  w_of;

   logic                  r_s2_valid;
   logic [MENT_WIDTH-1:0] r_s2_frac;
   logic [EXPO_WIDTH-1:0] r_s2_exp;
   logic                  r_s2_rb;
   logic                  r_s2_zero;
   logic                  r_s2_uf;
   logic                  r_s2_of;

   assign w_s2_adv     = !r_s2_valid || bus.out_ready;
   assign w_s1_adv     = !r_s1_valid || w_s2_adv;
   assign bus.in_ready = w_s1_adv;

   // Highest set bit wins: later iterations overwrite the count from lower bits.
   always_comb begin
      w_lz = LZW'(MENT_WIDTH + 1);
      for (int unsigned i = 0; i <= MENT_WIDTH; i++) begin
         if (bus.sum_in[i]) w_lz = LZW'(MENT_WIDTH - i);
      end
   end

   assign w_e_ext  = {1'b0, r_s1_exp};
   assign w_e_inc  = w_e_ext + 1'b1;
   assign w_lz_ext = XW'(r_s1_lz);

   always_comb begin
      w_shamt = '0;
      w_norm  = 1'b0;
      w_frac  = '0;
      w_exp   = '0;
      w_rb    = 1'b0;
      w_zero  = 1'b0;
      w_uf    = 1'b0;
      w_of    = 1'b0;
      if (r_s1_sum == '0) begin
         w_zero = 1'b1;
      end else if (r_s1_sum[MENT_WIDTH+1]) begin
         w_rb = r_s1_sum[0];
         if (w_e_inc >= EMAX) begin
            w_exp = '1;
            w_of  = 1'b1;
         end else begin
            w_frac = r_s1_sum[MENT_WIDTH:1];
            w_exp  = w_e_inc[EXPO_WIDTH-1:0];
         end
      end else if (r_s1_exp == '0) begin
         w_frac = r_s1_sum[MENT_WIDTH-1:0];
         w_exp  = EXPO_WIDTH'(r_s1_sum[MENT_WIDTH]);
      end else if (w_lz_ext < w_e_ext) begin
         w_norm  = 1'b1;
         w_shamt = r_s1_lz;
         w_exp   = EXPO_WIDTH'(w_e_ext - w_lz_ext);
      end else begin
         // Here e-1 < lz <= MENT_WIDTH, so the truncated shift amount is exact.
         w_norm  = 1'b1;
         w_shamt = LZW'(w_e_ext - 1'b1);
         w_uf    = 1'b1;
      end
      if (w_norm) w_frac = MENT_WIDTH'(r_s1_sum[MENT_WIDTH:0] << w_shamt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_exp   <= '0;
         r_s1_sum   <= '0;
         r_s1_lz    <= '0;
         r_s2_valid <= 1'b0;
         r_s2_frac  <= '0;
         r_s2_exp   <= '0;
         r_s2_rb    <= 1'b0;
         r_s2_zero  <= 1'b0;
         r_s2_uf    <= 1'b0;
         r_s2_of    <= 1'b0;
      end else begin
         if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               r_s1_exp <= bus.bigger_exponent_in;
               r_s1_sum <= bus.sum_in;
               r_s1_lz  <= w_lz;
            end
         end
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_frac <= w_frac;
               r_s2_exp  <= w_exp;
               r_s2_rb   <= w_rb;
               r_s2_zero <= w_zero;
               r_s2_uf   <= w_uf;
               r_s2_of   <= w_of;
            end
         end
      end
   end

   assign bus.out_valid               = r_s2_valid;
   assign bus.normalized_mentissa_out = r_s2_frac;
   assign bus.normalized_exponent_out = r_s2_exp;
   assign bus.round_bit_out           = r_s2_rb;
   assign bus.zero_out                = r_s2_zero;
   assign bus.underflow_out           = r_s2_uf;
   assign bus.overflow_out            = r_s2_of;
endmodule

// File: tb/tb_addition_normalizer_pipe.sv
// Directed and randomised bench for addition_normalizer_pipe with an in-order scoreboard of expected
// results, output-hold checks under backpressure, latency and reset-flush checks.
module tb_addition_normalizer_pipe;
   localparam int unsigned MW = 23;
   localparam int unsigned EW = 8;
   localparam int unsigned RW = MW + EW + 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   addition_normalizer_pipe_if #(.MENT_WIDTH(MW), .EXPO_WIDTH(EW)) bus ();

   addition_normalizer_pipe #(.MENT_WIDTH(MW), .EXPO_WIDTH(EW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int              errors = 0;
   int              checks = 0;
   int unsigned     cyc = 0;
   logic [RW-1:0]   sbq[$];
   int unsigned     pop_cyc[$];
   logic            rnd_ready = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [RW-1:0] pk(input logic [MW-1:0] f, input logic [EW-1:0] e,
                                        input logic rb, input logic z, input logic u, input logic o);
      return {f, e, rb, z, u, o};
   endfunction

   // Reference: normalise by single-bit steps until the hidden bit is set or exponent bottoms out.
   function automatic logic [RW-1:0] model(input logic [EW-1:0] e, input logic [MW+1:0] s);
      logic [MW:0]   m;
      int            x;
      logic [MW-1:0] f;
      logic [EW-1:0] ex;
      logic          rb, z, u, o;
      f = '0; ex = '0; rb = 1'b0; z = 1'b0; u = 1'b0; o = 1'b0;
      m = s[MW:0];
      x = int'(e);
      if (s == '0) z = 1'b1;
      else if (s[MW+1]) begin
         rb = s[0];
         if (x + 1 >= (1 << EW) - 1) begin ex = '1; o = 1'b1; end
         else begin f = s[MW:1]; ex = EW'(x + 1); end
      end else if (x == 0) begin
         f  = s[MW-1:0];
         ex = EW'(s[MW]);
      end else begin
         while (!m[MW] && x > 1) begin m = m << 1; x--; end
         f = m[MW-1:0];
         if (m[MW]) ex = EW'(x);
         else u = 1'b1;
      end
      return {f, ex, rb, z, u, o};
   endfunction

   task automatic monitor();
      logic [RW-1:0] obs, held_v, expv;
      logic          held;
      held = 1'b0;
      held_v = '0;
      forever begin
         @(negedge clk);
         cyc++;
         obs = {bus.normalized_mentissa_out, bus.normalized_exponent_out, bus.round_bit_out,
                bus.zero_out, bus.underflow_out, bus.overflow_out};
         if (rst) held = 1'b0;
         else if (bus.out_valid) begin
            if (held) chk("hold_stable", obs, held_v);
            if (bus.out_ready) begin
               chk("sb_has_entry", sbq.size() != 0, 1);
               if (sbq.size() != 0) begin
                  expv = sbq.pop_front();
                  chk("result", obs, expv);
                  pop_cyc.push_back(cyc);
               end
               held = 1'b0;
            end else begin
               held_v = obs;
               held   = 1'b1;
            end
         end else held = 1'b0;
      end
   endtask

   // Drives one operand from posedge+1 and returns at posedge+1 after it is accepted.
   task automatic send(input logic [EW-1:0] e, input logic [MW+1:0] s, input logic [RW-1:0] expv);
      logic acc;
      acc = 1'b0;
      bus.in_valid           = 1'b1;
      bus.bigger_exponent_in = e;
      bus.sum_in             = s;
      for (int i = 0; i < 64 && !acc; i++) begin
         if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
      end
      chk("accept_in_time", acc, 1);
      if (acc) sbq.push_back(expv);
   endtask

   task automatic drain();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
      chk("drain_empty", sbq.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [EW-1:0] re;
      logic [MW+1:0] rs;
      bus.in_valid           = 1'b0;
      bus.bigger_exponent_in = '0;
      bus.sum_in             = '0;
      bus.out_ready          = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_outputs", {bus.normalized_mentissa_out, bus.normalized_exponent_out, bus.round_bit_out,
                          bus.zero_out, bus.underflow_out, bus.overflow_out}, 0);
      fork monitor(); join_none
      @(posedge clk);
      #1;

      send(8'h80, 25'h1800000, pk(23'h400000, 8'h81, 0, 0, 0, 0));
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("latency_c1_idle", bus.out_valid, 0);
      @(negedge clk);
      chk("latency_c2_valid", bus.out_valid, 1);
      drain();

      send(8'h80, 25'h0200000, pk(23'h000000, 8'h7E, 0, 0, 0, 0));
      send(8'h80, 25'h0000001, pk(23'h000000, 8'h69, 0, 0, 0, 0));
      send(8'h03, 25'h0000100, pk(23'h000400, 8'h00, 0, 0, 1, 0));
      send(8'h80, 25'h0000000, pk(23'h000000, 8'h00, 0, 1, 0, 0));
      send(8'hFE, 25'h1000001, pk(23'h000000, 8'hFF, 1, 0, 0, 1));
      send(8'hFD, 25'h1000001, pk(23'h000000, 8'hFE, 1, 0, 0, 0));
      send(8'h00, 25'h0812345, pk(23'h012345, 8'h01, 0, 0, 0, 0));
      send(8'h00, 25'h0012345, pk(23'h012345, 8'h00, 0, 0, 0, 0));
      send(8'h05, 25'h0800000 >> 4, pk(23'h000000, 8'h01, 0, 0, 0, 0));
      drain();

      bus.out_ready = 1'b0;
      send(8'h40, 25'h0123456, model(8'h40, 25'h0123456));
      send(8'h41, 25'h1ABCDEF, model(8'h41, 25'h1ABCDEF));
      bus.bigger_exponent_in = 8'h42;
      bus.sum_in             = 25'h0000F00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_in_ready_low", bus.in_ready, 0);
         chk("bp_out_valid_held", bus.out_valid, 1);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      pop_cyc.delete();
      send(8'h42, 25'h0000F00, model(8'h42, 25'h0000F00));
      send(8'h02, 25'h0000F00, model(8'h02, 25'h0000F00));
      drain();
      chk("bp_pop_count", pop_cyc.size(), 4);
      if (pop_cyc.size() == 4)
         for (int i = 1; i < 4; i++) chk("bp_back_to_back", pop_cyc[i] - pop_cyc[i-1], 1);

      bus.out_ready = 1'b0;
      send(8'h70, 25'h0400000, model(8'h70, 25'h0400000));
      send(8'h71, 25'h0300000, model(8'h71, 25'h0300000));
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sbq.delete();
      @(negedge clk);
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_in_ready", bus.in_ready, 1);
      chk("midrst_outputs", {bus.normalized_mentissa_out, bus.normalized_exponent_out, bus.round_bit_out,
                             bus.zero_out, bus.underflow_out, bus.overflow_out}, 0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("midrst_no_stale", bus.out_valid, 0);
      end
      @(posedge clk);
      #1;

      rnd_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         re = EW'($urandom_range(0, 254));
         rs = (MW + 2)'($urandom) >> $urandom_range(0, MW + 1);
         if (re == '0) rs[MW+1] = 1'b0;
         send(re, rs, model(re, rs));
      end
      rnd_ready = 1'b0;
      bus.out_ready = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
